mdu_seq: RTL

- Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- The ALU takes operands and produces a result in the same cycle. This block takes the MULT/MULTU/DIV/DIVU operations the ALU cannot complete in one cycle.
- It owns the architectural HI/LO registers.
- Control issues an operation with start; the pipeline waits on busy and sees done when HI/LO are valid.

---
 rtl/mdu_seq.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq -- sequential multiply/divide unit with architectural HI/LO.
//
// Sits beside the single-cycle ALU and handles MULT, MULTU, DIV and DIVU,
// which take WIDTH iterations. MTHI/MTLO write HI/LO directly.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset; aborts any operation in flight
//   start  issue request, only honoured while busy=0
//   op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//          110/111 are ignored
//   A      rs operand: multiplicand, dividend or MTHI/MTLO source
//   B      rt operand: multiplier or divisor
//   busy   high while a multiply/divide runs (RUN and FIX states)
//   done   one-cycle pulse in the cycle after HI/LO were written
//   hi     HI register (product high half or remainder)
//   lo     LO register (product low half or quotient)
//
// Latency: with start taken at edge E0, busy is high for WIDTH+1 cycles
// (WIDTH RUN iterations plus one FIX cycle). done and the new HI/LO show
// up together, and busy is already low in that cycle. A new op can be
// issued in that same cycle.
// ---------------------------------------------------------------------------
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_reg;
  logic [CW-1:0] cnt_reg;

  // The 2*WIDTH accumulator serves both algorithms.
  //   multiply: {partial product high half, remaining multiplier bits}
  //   divide:   {partial remainder, dividend bits / quotient bits}
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;

  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0] opnd_reg;

  logic is_div_reg;
  logic neg_q_reg;     // negate product / quotient in FIX
  logic neg_r_reg;     // negate remainder in FIX (sign of the dividend)
  logic div_zero_reg;  // divisor was zero

  logic             done_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  // ---------------------------------------------------------------------
  // Issue-side decode and operand magnitudes
  // ---------------------------------------------------------------------
  logic             op_muldiv;
  logic             op_div;
  logic             op_signed;
  logic             op_mthi;
  logic             op_mtlo;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign op_muldiv = ~op[2];
  assign op_div    = op[1];
  assign op_signed = ~op[0];
  assign op_mthi   = (op == 3'b100);
  assign op_mtlo   = (op == 3'b101);

  assign a_neg = op_signed & A[WIDTH-1];
  assign b_neg = op_signed & B[WIDTH-1];

  // The most negative value negates to itself. Read as unsigned, that is
  // exactly its magnitude, so no extra bit is needed.
  assign mag_a = a_neg ? (-A) : A;
  assign mag_b = b_neg ? (-B) : B;

  // ---------------------------------------------------------------------
  // Multiply iteration: shift-add, LSB of the accumulator selects the add
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mul_addend
    assign mul_addend[gi] = opnd_reg[gi] & acc_reg[0];
  end

  // The carry out of the add becomes the new top bit after the shift.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

  // ---------------------------------------------------------------------
  // Divide iteration: restoring, one quotient bit per cycle
  // ---------------------------------------------------------------------
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_step;

  // Bring the next dividend bit into the remainder. The remainder is always
  // below the divisor, so the shifted value is below twice the divisor.
  // That means the trial difference's top bit is a clean borrow flag.
  assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_reg};
  assign div_rem   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_step  = {div_rem, acc_reg[WIDTH-2:0], ~div_trial[WIDTH]};

  // With a zero divisor the accumulator is frozen. The dividend magnitude
  // then survives to FIX, where it is turned back into A for HI.
  always_comb begin
    acc_next = acc_reg;
    if (is_div_reg) begin
      if (!div_zero_reg) begin
        acc_next = div_step;
      end
    end else begin
      acc_next = mul_step;
    end
  end

  // ---------------------------------------------------------------------
  // Sign correction applied in FIX
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign prod_fix = neg_q_reg ? (-acc_reg) : acc_reg;
  assign quot_fix = neg_q_reg ? (-acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_r_reg ? (-acc_reg[2*WIDTH-1:WIDTH]) : acc_reg[2*WIDTH-1:WIDTH];

  // Signed overflow (most negative / -1) needs no special case. The
  // magnitude quotient 2^(WIDTH-1) negates to itself, and the remainder is 0.
  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (div_zero_reg) begin
        fix_hi = neg_r_reg ? (-acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0];
        fix_lo = '1;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quot_fix;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered HI/LO/done
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      opnd_reg     <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      done_reg     <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (op_muldiv) begin
              is_div_reg   <= op_div;
              neg_q_reg    <= a_neg ^ b_neg;
              neg_r_reg    <= a_neg;
              div_zero_reg <= op_div & (B == '0);
              cnt_reg      <= CNT_LOAD;
              if (op_div) begin
                acc_reg  <= {{WIDTH{1'b0}}, mag_a};
                opnd_reg <= mag_b;
              end else begin
                acc_reg  <= {{WIDTH{1'b0}}, mag_b};
                opnd_reg <= mag_a;
              end
              state_reg <= RUN;
            end else if (op_mthi) begin
              hi_reg   <= A;
              done_reg <= 1'b1;
            end else if (op_mtlo) begin
              lo_reg   <= A;
              done_reg <= 1'b1;
            end
          end
        end

        RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= FIX;
          end
        end

        FIX: begin
          hi_reg    <= fix_hi;
          lo_reg    <= fix_lo;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
